rv_dmem_responder: RTL and testbench
====================================

Name: rv_dmem_responder

Overview:
- AHB-lite-style data-memory responder for the rv32 core's data port. It is the slave end of the core's dmaddr/dmdata/dmwr_req/dmwr_mask/htrans/hready/hresp interface.
- Holds a word-organised memory array and accepts pipelined address/data-phase transfers.
- Inserts a fixed number of wait states and writes with per-byte masks.
- Replaces the zero-latency D_cache model in core benches so the stall and error paths get exercised.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array. Must be a power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0. Must be aligned to DEPTH_WORDS*4.
- WAIT_STATES, 0: hready-low cycles inserted in every OKAY data phase. Range 0..15.

Ports:
- clk_in  input  1  clock; all state changes on rising edge
- rst_in  input  1  reset, asynchronous, active-high
- dmaddr_in  input  32  address-phase byte address from core
- data_htrans_in  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- dmwr_req_in  input  1  address-phase write flag: 1 = write, 0 = read
- dmwr_mask_in  input  4  address-phase byte enables; bit i covers byte i (bits 8i+7:8i)
- dmdata_in  input  32  write data, valid in data phase
- dmdata_out  output  32  read data, valid when data_hready_out=1 in a read data phase
- data_hready_out  output  1  transfer-done / ready to accept an address
- hresp_out  output  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset:
  - data_hready_out=1, hresp_out=0, dmdata_out=0.
  - Pending-transfer flag is cleared and the wait counter is set to 0. State goes to IDLE.
  - Memory contents are not reset.
- Address accept:
  - At a rising edge where data_hready_out=1 and data_htrans_in[1]=1, the block latches word index, write flag and mask.
  - Word index = (dmaddr_in-BASE_ADDR)>>2. dmaddr_in[1:0] is ignored.
  - htrans 00/01 is not accepted and always gets a zero-wait OKAY.
- States:
  - IDLE: no pending transfer. hready=1, hresp=0.
  - WAIT: pending OKAY transfer with counter >0. hready=0. Counter decrements each cycle. Goes to DATA when the counter reaches 0.
  - DATA: hready=1, hresp=0. The transfer completes at this edge.
  - ERR1: hready=0, hresp=1. Always goes to ERR2.
  - ERR2: hready=1, hresp=1. Completes the errored transfer.
- Transitions out of IDLE, DATA and ERR2 (states where hready=1):
  - Accepted in-range address with WAIT_STATES=0 -> DATA.
  - Accepted in-range address with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES.
  - Accepted out-of-range address -> ERR1.
  - No accept -> IDLE.
- Latency: an accepted transfer completes WAIT_STATES+1 cycles after address accept. Back-to-back transfers at zero wait run at one per cycle.
- Write commit:
  - Happens at the DATA-state edge. Byte i of mem[index] gets dmdata_in byte i where mask[i]=1. Bytes with mask[i]=0 are unchanged.
  - Mask 0000 is a legal no-op write with an OKAY response.
  - Errored writes never modify memory.
- Read data:
  - In DATA state with a read, dmdata_out = mem[index], combinational from the array.
  - Otherwise dmdata_out = 0.
  - A read whose data phase directly follows a write to the same word returns the newly written value.
- Simultaneous events: completing one transfer and accepting the next at the same edge is legal. Both take effect.
- Reset mid-transfer: a pending write is dropped (memory unchanged) and outputs return to reset values immediately.
- Arithmetic: the range check and index use 32-bit unsigned subtraction. An address below BASE_ADDR wraps to a large value and is out of range.

Optional Feature:
- DMEM_ERR_RESP_EN.
- Defined: out-of-range addresses (offset >= DEPTH_WORDS*4) take the two-cycle ERR1/ERR2 response described above.
- Undefined:
  - ERR1/ERR2 are removed and hresp_out is tied 0.
  - The index is taken modulo DEPTH_WORDS, so every address aliases into the array and gets a normal OKAY response with wait states.

Test Plan:
- WAIT_STATES=0: write 32'hDEAD_BEEF mask 1111 to 0x10, then read 0x10 -> hready stays 1 throughout, read returns 32'hDEAD_BEEF, hresp=0.
- Byte mask: after the step above, write 32'h0000_5500 mask 0010 to 0x10, read back -> 32'hDEAD_55EF.
- WAIT_STATES=2: read 0x10 -> hready=0 for exactly 2 cycles after accept, then 1 with data 32'hDEAD_55EF. The next address is accepted only on the hready=1 edge.
- DMEM_ERR_RESP_EN defined, DEPTH_WORDS=1024: write to 0x1000 -> hresp=1/hready=0, then hresp=1/hready=1. A later read of 0x0 is unchanged. Undefined: the same write aliases to word 0 and reads back.
- Pipelined: NONSEQ write 0x20 = 32'h1234_5678, then immediate SEQ read 0x20 at zero wait -> read data 32'h1234_5678 one cycle after the write completes.
- Assert rst_in during WAIT of a write to 0x30 -> hready=1 and hresp=0 at once, and a later read of 0x30 returns the old value.

Source files
------------

// File: rtl/rv_dmem_responder.sv
// AHB-lite-style data-memory responder for the rv32 core data port: pipelined transfers,
// fixed wait states, byte-masked writes. Define DMEM_ERR_RESP_EN for ERROR on out-of-range.
module rv_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] dmaddr_in,
    input  logic [1:0]  data_htrans_in,
    input  logic        dmwr_req_in,
    input  logic [3:0]  dmwr_mask_in,
    input  logic [31:0] dmdata_in,
    output logic [31:0] dmdata_out,
    output logic        data_hready_out,
    output logic        hresp_out
);

    localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WaitLoad = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData
`ifdef DMEM_ERR_RESP_EN
        ,
        StErr1,
        StErr2
`endif
    } state_e;

    state_e          state_q;
    logic            hready_q;
    logic [3:0]      cnt_q;
    logic [IdxW-1:0] idx_q;
    logic            wr_q;
    logic [3:0]      mask_q;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic [31:0]     offset;
    logic [IdxW-1:0] idx_new;
    logic            accept;

    assign offset  = dmaddr_in - BASE_ADDR;
    // Depth is a power of two, so truncating the word offset is the aliasing modulo.
    assign idx_new = IdxW'(offset >> 2);
    assign accept  = hready_q && data_htrans_in[1];

`ifdef DMEM_ERR_RESP_EN
    logic in_range;
    assign in_range = {1'b0, offset} < (33'(DEPTH_WORDS) << 2);
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= StIdle;
            hready_q <= 1'b1;
            cnt_q    <= '0;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            mask_q   <= '0;
        end else begin
            case (state_q)
                StWait: begin
                    if (cnt_q <= 4'd1) begin
                        state_q  <= StData;
                        hready_q <= 1'b1;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
`ifdef DMEM_ERR_RESP_EN
                StErr1: begin
                    state_q  <= StErr2;
                    hready_q <= 1'b1;
                end
`endif
                // Idle, data and final-error states all have hready high and may accept.
                default: begin
                    if (accept) begin
                        idx_q  <= idx_new;
                        wr_q   <= dmwr_req_in;
                        mask_q <= dmwr_mask_in;
`ifdef DMEM_ERR_RESP_EN
                        if (!in_range) begin
                            state_q  <= StErr1;
                            hready_q <= 1'b0;
                        end else
`endif
                        if (WAIT_STATES == 0) begin
                            state_q  <= StData;
                            hready_q <= 1'b1;
                        end else begin
                            state_q  <= StWait;
                            hready_q <= 1'b0;
                            cnt_q    <= WaitLoad;
                        end
                    end else begin
                        state_q  <= StIdle;
                        hready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Contents are deliberately not reset; a reset drops the pending write via state_q.
    always_ff @(posedge clk_in) begin
        if (state_q == StData && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= dmdata_in[8*i +: 8];
                end
            end
        end
    end

    assign data_hready_out = hready_q;
    assign dmdata_out      = (state_q == StData && !wr_q) ? mem_q[idx_q] : 32'h0;

`ifdef DMEM_ERR_RESP_EN
    assign hresp_out = (state_q == StErr1) || (state_q == StErr2);
`else
    assign hresp_out = 1'b0;
`endif

endmodule

// File: tb/tb_rv_dmem_responder.sv
// Self-checking bench for rv_dmem_responder: one zero-wait and one two-wait instance, a
// transaction-level reference model, vector table, hand sequences and random traffic.
module tb_rv_dmem_responder;

`ifdef DMEM_ERR_RESP_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    localparam logic [1:0] HtIdle = 2'b00, HtBusy = 2'b01, HtNonseq = 2'b10, HtSeq = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  htr [2];
    logic [31:0] addr, a_wdata, junk, dmdata_bus;
    logic        wr;
    logic [3:0]  mask;
    int          a_tag, sel;
    logic [31:0] rdata [2];
    logic        hrdy [2];
    logic        hrsp [2];
    logic        chk_en = 1'b0;
    int          checks = 0, failures = 0;
    logic [31:0] tag_exp [64];

    // Reference model: one pending transfer per DUT, counting cycles until completion.
    logic        pv [2], pw [2], pe [2];
    logic [3:0]  pm [2];
    logic [9:0]  pi [2];
    int          pl [2], ptag [2];
    logic [31:0] pwd [2];
    logic [31:0] mm [2][1024];

    always #5 clk = ~clk;

    assign dmdata_bus = (pv[sel] && pw[sel]) ? pwd[sel] : junk;

    rv_dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u_dut0 (
        .clk_in(clk), .rst_in(rst), .dmaddr_in(addr), .data_htrans_in(htr[0]),
        .dmwr_req_in(wr), .dmwr_mask_in(mask), .dmdata_in(dmdata_bus),
        .dmdata_out(rdata[0]), .data_hready_out(hrdy[0]), .hresp_out(hrsp[0])
    );

    rv_dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0001_0000), .WAIT_STATES(2)) u_dut2 (
        .clk_in(clk), .rst_in(rst), .dmaddr_in(addr), .data_htrans_in(htr[1]),
        .dmwr_req_in(wr), .dmwr_mask_in(mask), .dmdata_in(dmdata_bus),
        .dmdata_out(rdata[1]), .data_hready_out(hrdy[1]), .hresp_out(hrsp[1])
    );

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? 32'h0000_0000 : 32'h0001_0000;
    endfunction
    function automatic logic [31:0] depth_of(input int d);
        return (d == 0) ? 32'd1024 : 32'd256;
    endfunction
    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction
    function automatic logic err_of(input int d, input logic [31:0] a);
        logic [31:0] off;
        off = a - base_of(d);
        return ErrEn && (off >= depth_of(d) * 32'd4);
    endfunction
    function automatic logic [9:0] idx_of(input int d, input logic [31:0] a);
        logic [31:0] off;
        off = a - base_of(d);
        return 10'((off >> 2) % depth_of(d));
    endfunction
    function automatic logic [31:0] fillv(input int d, input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0101) ^ (32'(d) << 20);
    endfunction
    function automatic logic exp_hready(input int d);
        return !pv[d] || pl[d] == 1;
    endfunction
    function automatic logic exp_hresp(input int d);
        return pv[d] && pe[d];
    endfunction
    function automatic logic [31:0] exp_rdata(input int d);
        return (pv[d] && pl[d] == 1 && !pe[d] && !pw[d]) ? mm[d][pi[d]] : 32'h0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv[0] <= 1'b0;
            pv[1] <= 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (pv[d] && pl[d] == 1) begin
                    pv[d] <= 1'b0;
                    if (pw[d] && !pe[d]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (pm[d][b]) mm[d][pi[d]][8*b +: 8] <= pwd[d][8*b +: 8];
                        end
                    end
                end else if (pv[d]) begin
                    pl[d] <= pl[d] - 1;
                end
                if (exp_hready(d) && htr[d][1]) begin
                    pv[d]   <= 1'b1;
                    pw[d]   <= wr;
                    pm[d]   <= mask;
                    pwd[d]  <= a_wdata;
                    ptag[d] <= a_tag;
                    pi[d]   <= idx_of(d, addr);
                    pe[d]   <= err_of(d, addr);
                    pl[d]   <= err_of(d, addr) ? 2 : ws_of(d) + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("hready%0d", d), 32'(hrdy[d]), 32'(exp_hready(d)));
                check($sformatf("hresp%0d", d), 32'(hrsp[d]), 32'(exp_hresp(d)));
                check($sformatf("rdata%0d", d), rdata[d], exp_rdata(d));
                if (pv[d] && pl[d] == 1 && !pw[d] && !pe[d] && ptag[d] >= 0)
                    check($sformatf("tag%0d_rdata", ptag[d]), rdata[d], tag_exp[ptag[d]]);
            end
        end
    end

    // Present one transfer and hold it until the model says it was accepted.
    task automatic issue(input int d, input logic [1:0] tr, input logic w, input logic [31:0] a,
                         input logic [3:0] m, input logic [31:0] wd, input int tag);
        logic hr;
        int   n;
        htr[d] = tr; addr = a; wr = w; mask = m; a_wdata = wd; a_tag = tag; junk = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            hr = exp_hready(d);
            @(posedge clk);
            #1;
            n++;
        end while (!hr && n < 40);
        if (!hr) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: dut %0d not ready after %0d cycles, required <40", d, n);
        end
    endtask

    task automatic idle(input int d, input logic [1:0] tr, input int n);
        htr[d] = tr; addr = $urandom; wr = 1'($urandom); mask = 4'($urandom); a_tag = -1;
        repeat (n) begin
            junk = $urandom;
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [3:0]  m;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [12];

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] fv;
        int          n;
        htr[0] = HtIdle; htr[1] = HtIdle; addr = '0; wr = 1'b0; mask = '0;
        a_wdata = '0; a_tag = -1; junk = '0; sel = 0;
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_hready%0d", d), 32'(hrdy[d]), 32'd1);
            check($sformatf("reset_hresp%0d", d), 32'(hrsp[d]), 32'd0);
            check($sformatf("reset_rdata%0d", d), rdata[d], 32'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Fill both arrays with known words so every later read is defined.
        for (int d = 0; d < 2; d++) begin
            sel = d;
            for (int i = 0; i < int'(depth_of(d)); i++)
                issue(d, (i == 0) ? HtNonseq : HtSeq, 1'b1, base_of(d) + 32'(i) * 32'd4,
                      4'hF, fillv(d, i), -1);
            idle(d, HtIdle, 4);
        end

        sel = 0;
        fv = fillv(0, 11);
        tbl[0]  = '{1'b1, 32'h10,   4'hF, 32'hDEAD_BEEF, 32'h0};
        tbl[1]  = '{1'b0, 32'h10,   4'h0, 32'h0,         32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 32'h10,   4'h2, 32'h0000_5500, 32'h0};
        tbl[3]  = '{1'b0, 32'h10,   4'h0, 32'h0,         32'hDEAD_55EF};
        tbl[4]  = '{1'b1, 32'h20,   4'hF, 32'h1234_5678, 32'h0};
        tbl[5]  = '{1'b0, 32'h20,   4'h0, 32'h0,         32'h1234_5678};
        tbl[6]  = '{1'b1, 32'h14,   4'h0, 32'hAAAA_AAAA, 32'h0};
        tbl[7]  = '{1'b0, 32'h14,   4'h0, 32'h0,         fillv(0, 5)};
        tbl[8]  = '{1'b1, 32'h1000, 4'hF, 32'hCAFE_F00D, 32'h0};
        tbl[9]  = '{1'b0, 32'h0,    4'h0, 32'h0,         ErrEn ? fillv(0, 0) : 32'hCAFE_F00D};
        tbl[10] = '{1'b0, 32'h13,   4'h0, 32'h0,         32'hDEAD_55EF};
        tbl[11] = '{1'b1, 32'h2C,   4'h9, 32'h1122_3344, 32'h0};
        for (int i = 0; i < 12; i++) begin
            tag_exp[i] = tbl[i].exp;
            issue(0, (i == 0) ? HtNonseq : HtSeq, tbl[i].w, tbl[i].a, tbl[i].m, tbl[i].wd,
                  tbl[i].w ? -1 : i);
        end
        tag_exp[12] = {8'h11, fv[23:8], 8'h44};
        issue(0, HtSeq, 1'b0, 32'h2C, 4'h0, 32'h0, 12);
        idle(0, HtIdle, 3);

`ifdef DMEM_ERR_RESP_EN
        issue(0, HtNonseq, 1'b1, 32'h1000, 4'hF, 32'h0BAD_0BAD, -1);
        htr[0] = HtIdle;
        @(negedge clk);
        check("err1_hresp", 32'(hrsp[0]), 32'd1);
        check("err1_hready", 32'(hrdy[0]), 32'd0);
        @(negedge clk);
        check("err2_hresp", 32'(hrsp[0]), 32'd1);
        check("err2_hready", 32'(hrdy[0]), 32'd1);
        idle(0, HtIdle, 2);
`endif

        // Two wait states: hready must stay low for exactly two cycles after accept.
        sel = 1;
        tag_exp[51] = fillv(1, 4);
        issue(1, HtNonseq, 1'b0, 32'h0001_0010, 4'h0, 32'h0, 51);
        htr[1] = HtIdle;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (hrdy[1]) break;
            n++;
        end
        check("ws2_low_cycles", 32'(n), 32'd2);
        idle(1, HtIdle, 2);
        tag_exp[52] = fillv(1, 5);
        tag_exp[53] = fillv(1, 6);
        issue(1, HtNonseq, 1'b0, 32'h0001_0014, 4'h0, 32'h0, 52);
        issue(1, HtSeq, 1'b0, 32'h0001_0018, 4'h0, 32'h0, 53);
        idle(1, HtIdle, 4);

        // Reset while a write waits: outputs return at once, memory keeps the old word.
        issue(1, HtNonseq, 1'b1, 32'h0001_0030, 4'hF, 32'hBAD0_BAD0, -1);
        htr[1] = HtIdle;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_hready", 32'(hrdy[1]), 32'd1);
        check("rst_mid_hresp", 32'(hrsp[1]), 32'd0);
        check("rst_mid_rdata", rdata[1], 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1, HtIdle, 2);
        tag_exp[54] = fillv(1, 12);
        issue(1, HtNonseq, 1'b0, 32'h0001_0030, 4'h0, 32'h0, 54);
        idle(1, HtIdle, 4);

        // Random traffic including BUSY/IDLE, byte masks and out-of-range addresses.
        for (int d = 0; d < 2; d++) begin
            sel = d;
            for (int k = 0; k < 400; k++) begin
                int unsigned r;
                logic [31:0] a;
                r = $urandom_range(0, 9);
                if (d == 0) a = 32'($urandom_range(0, 32'h17FF));
                else        a = 32'h0000_FF00 + 32'($urandom_range(0, 32'h600));
                if (r < 2) idle(d, (r == 0) ? HtIdle : HtBusy, 1 + int'($urandom_range(0, 2)));
                else issue(d, (r[0]) ? HtSeq : HtNonseq, 1'($urandom), a, 4'($urandom),
                           $urandom, -1);
            end
            idle(d, HtIdle, 5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
